// File: rtl/typewriter_ctrl.sv
// Typewriter character-buffer controller: clears the screen RAM, then applies
// keystrokes (printable, backspace, return, form feed) at a moving cursor.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_CLEAR | writing 0x20 to every cell, ascending from address 0
//   S_IDLE  | waiting for a key (pending key takes priority)
//   S_EXEC  | applying the latched key for exactly one cycle
module typewriter_ctrl #(
    parameter int ADDR_W = 6,
    parameter int LINE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [7:0]        key_ascii,
    input  logic              clear_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy,
    output logic              key_drop
);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_EXEC} state_t;

    localparam logic [7:0] C_SPACE = 8'h20;
    localparam logic [7:0] C_TILDE = 8'h7E;
    localparam logic [7:0] C_BS    = 8'h08;
    localparam logic [7:0] C_CR    = 8'h0D;
    localparam logic [7:0] C_FF    = 8'h0C;

    state_t            r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr,  w_clr_addr_nxt;
    logic [ADDR_W-1:0] r_cursor,    w_cursor_nxt;
    logic              r_pend_vld,  w_pend_vld_nxt;
    logic [7:0]        r_pend_key,  w_pend_key_nxt;
    logic [7:0]        r_exec_key,  w_exec_key_nxt;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [7:0]        r_hold_data;

    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_wdata;
    logic              w_drop;
    logic              w_printable;
    logic [ADDR_W-1:0] w_line_inc;

    assign w_printable = (r_exec_key >= C_SPACE) && (r_exec_key <= C_TILDE);
    assign w_line_inc  = (r_cursor >> LINE_W) + 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_cursor_nxt   = r_cursor;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_key_nxt = r_pend_key;
        w_exec_key_nxt = r_exec_key;
        w_we           = 1'b0;
        w_addr         = r_hold_addr;
        w_wdata        = r_hold_data;
        w_drop         = 1'b0;

        case (r_state)
            S_CLEAR: begin
                w_we         = 1'b1;
                w_addr       = r_clr_addr;
                w_wdata      = C_SPACE;
                w_cursor_nxt = '0;
                if (&r_clr_addr) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            S_IDLE: begin
                // The pending slot frees this cycle, so a new key can refill it.
                if (r_pend_vld) begin
                    w_exec_key_nxt = r_pend_key;
                    w_pend_vld_nxt = key_valid;
                    if (key_valid) w_pend_key_nxt = key_ascii;
                    w_state_nxt    = S_EXEC;
                end else if (key_valid) begin
                    w_exec_key_nxt = key_ascii;
                    w_state_nxt    = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_IDLE;
                if (w_printable) begin
                    w_we         = 1'b1;
                    w_addr       = r_cursor;
                    w_wdata      = r_exec_key;
                    w_cursor_nxt = r_cursor + 1'b1;
                end else if (r_exec_key == C_BS) begin
                    if (r_cursor != '0) begin
                        w_we         = 1'b1;
                        w_addr       = r_cursor - 1'b1;
                        w_wdata      = C_SPACE;
                        w_cursor_nxt = r_cursor - 1'b1;
                    end
                end else if (r_exec_key == C_CR) begin
                    w_cursor_nxt = w_line_inc << LINE_W;
                end else if (r_exec_key == C_FF) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = S_CLEAR;
                w_clr_addr_nxt = '0;
            end
        endcase

        if (r_state != S_IDLE && key_valid) begin
            if (!r_pend_vld) begin
                w_pend_vld_nxt = 1'b1;
                w_pend_key_nxt = key_ascii;
            end else begin
                w_drop = 1'b1;
            end
        end

        // A clear discards the old pending key but keeps a coincident one.
        if (clear_req) begin
            w_state_nxt    = S_CLEAR;
            w_clr_addr_nxt = '0;
            w_pend_vld_nxt = key_valid;
            w_pend_key_nxt = key_valid ? key_ascii : r_pend_key;
            w_drop         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_CLEAR;
            r_clr_addr  <= '0;
            r_cursor    <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_key  <= '0;
            r_exec_key  <= '0;
            r_hold_addr <= '0;
            r_hold_data <= C_SPACE;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_cursor   <= w_cursor_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_key <= w_pend_key_nxt;
            r_exec_key <= w_exec_key_nxt;
            if (w_we) begin
                r_hold_addr <= w_addr;
                r_hold_data <= w_wdata;
            end
        end
    end

    // Outputs are quiet while reset is held, even though the state sits in S_CLEAR.
    assign ram_we    = w_we & ~reset;
    assign ram_addr  = reset ? r_hold_addr : w_addr;
    assign ram_wdata = reset ? r_hold_data : w_wdata;
    assign key_drop  = w_drop & ~reset;
    assign cursor    = r_cursor;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_typewriter_ctrl.sv
// Randomized scoreboard bench for typewriter_ctrl: a keystroke-level screen
// model predicts every RAM write, the cursor position and the dropped-key count.
module tb_typewriter_ctrl;

    localparam int AW    = 6;
    localparam int LW    = 4;
    localparam int CELLS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          key_valid;
    logic [7:0]    key_ascii;
    logic          clear_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [AW-1:0] cursor;
    logic          busy;
    logic          key_drop;

    typewriter_ctrl #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_ascii (key_ascii),
        .clear_req (clear_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cursor    (cursor),
        .busy      (busy),
        .key_drop  (key_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  bq[$];
    int  n_checks   = 0;
    int  n_fail     = 0;
    int  m_cursor   = 0;
    int  exp_drops  = 0;
    int  obs_drops  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic void push_wr(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void push_clear(input int n);
        for (int i = 0; i < n; i++) push_wr(i, 32);
    endfunction

    // Screen model: what a key does to the buffer and cursor.
    function automatic void apply_key(input int k);
        if (k >= 32 && k <= 126) begin
            push_wr(m_cursor, k);
            m_cursor = (m_cursor + 1) % CELLS;
        end else if (k == 8) begin
            if (m_cursor != 0) begin
                m_cursor = m_cursor - 1;
                push_wr(m_cursor, 32);
            end
        end else if (k == 13) begin
            m_cursor = ((m_cursor / (1 << LW)) + 1) * (1 << LW) % CELLS;
        end else if (k == 12) begin
            push_clear(CELLS);
            m_cursor = 0;
        end
    endfunction

    // Monitor: every RAM write must match the head of the expected queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected at %0t",
                             ram_addr, ram_wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(ram_addr), e.addr);
                    chk("wr_data", int'(ram_wdata), e.data);
                end
            end
            if (busy === 1'b0) chk("we_in_idle", int'(ram_we), 0);
            if (key_drop === 1'b1) obs_drops++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy !== 1'b0 && i < budget) begin
            tick();
            i++;
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    task automatic settle();
        repeat (6) tick();
        wait_idle(300);
        repeat (4) tick();
        wait_idle(300);
        chk("cursor", int'(cursor), m_cursor);
    endtask

    // Sends bq on consecutive cycles; bursts of up to 3 never overflow.
    task automatic send_burst();
        while (bq.size() != 0) begin
            int k = bq.pop_front();
            key_valid = 1'b1;
            key_ascii = 8'(k);
            apply_key(k);
            tick();
        end
        key_valid = 1'b0;
        settle();
    endtask

    task automatic type_n(input int n);
        for (int i = 0; i < n; i++) begin
            bq.push_back(int'($urandom_range(32, 126)));
            send_burst();
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ram_we",   int'(ram_we),    0);
        chk("rst_ram_addr", int'(ram_addr),  0);
        chk("rst_wdata",    int'(ram_wdata), 32);
        chk("rst_busy",     int'(busy),      1);
        chk("rst_key_drop", int'(key_drop),  0);
        chk("rst_cursor",   int'(cursor),    0);
    endtask

    function automatic int rand_key();
        int others[8] = '{0, 7, 9, 10, 27, 127, 128, 255};
        int r = int'($urandom_range(0, 9));
        if (r <= 5) return int'($urandom_range(32, 126));
        if (r == 6) return 8;
        if (r <= 8) return 13;
        return others[$urandom_range(0, 7)];
    endfunction

    initial begin
        int p;
        int q;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        clear_req = 1'b0;
        repeat (3) tick();
        chk_reset_outputs();

        // Power-up clear of all 64 cells.
        push_clear(CELLS);
        m_cursor = 0;
        reset = 1'b0;
        repeat (70) tick();
        chk("boot_busy", int'(busy), 0);
        chk("boot_cursor", int'(cursor), 0);
        chk("boot_writes_left", exp_q.size(), 0);

        // "Hi" then backspace.
        bq = '{72, 105, 8};
        send_burst();

        // Return from mid-line, from line 3 (wraps), backspace at 0.
        type_n(4);
        bq = '{13};
        send_burst();
        type_n(34);
        bq = '{13};
        send_burst();
        bq = '{8};
        send_burst();

        // Printable at the last cell wraps the cursor.
        type_n(63);
        bq = '{65};
        send_burst();

        // Three back-to-back keys, then a form feed.
        bq = '{49, 50, 51};
        send_burst();
        bq = '{12};
        send_burst();

        for (int b = 0; b < 40; b++) begin
            int n = int'($urandom_range(1, 3));
            for (int j = 0; j < n; j++) bq.push_back(rand_key());
            send_burst();
        end

        // Two keys during a clear: first pends and runs after, second drops.
        p = int'($urandom_range(32, 126));
        q = int'($urandom_range(32, 126));
        push_clear(CELLS);
        m_cursor = 0;
        apply_key(p);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        key_valid = 1'b1;
        key_ascii = 8'(p);
        tick();
        key_ascii = 8'(q);
        tick();
        exp_drops++;
        key_valid = 1'b0;
        settle();

        // clear_req mid-clear restarts at 0 and flushes the pending key.
        push_clear(10);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        key_valid = 1'b1;
        key_ascii = 8'(p);
        tick();
        key_ascii = 8'(q);
        tick();
        exp_drops++;
        key_valid = 1'b0;
        repeat (7) tick();
        push_clear(CELLS);
        m_cursor = 0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        settle();

        // Key coincident with clear_req runs after the clear.
        push_clear(CELLS);
        m_cursor = 0;
        apply_key(q);
        clear_req = 1'b1;
        key_valid = 1'b1;
        key_ascii = 8'(q);
        tick();
        clear_req = 1'b0;
        key_valid = 1'b0;
        settle();

        // Reset mid-clear aborts it and discards the pending key.
        push_clear(5);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        key_valid = 1'b1;
        key_ascii = 8'(p);
        tick();
        key_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk_reset_outputs();
        tick();
        push_clear(CELLS);
        m_cursor = 0;
        reset = 1'b0;
        settle();

        repeat (5) tick();
        chk("drop_count", obs_drops, exp_drops);
        chk("writes_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/typewriter_ctrl.md
TYPEWRITER_CTRL -- requirements
Module: typewriter_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning character-buffer address width (64 cells).
REQ-002 SHALL have parameter LINE_W, default 4, meaning log2 of cells per display line (16).
REQ-003 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port key_valid  in  1  one-cycle pulse, key_ascii valid.
REQ-006 SHALL have port key_ascii  in  8  ASCII code of the pressed key.
REQ-007 SHALL have port clear_req  in  1  one-cycle pulse requesting a screen clear.
REQ-008 SHALL have port ram_we  out  1  write enable to the character RAM.
REQ-009 SHALL have port ram_addr  out  ADDR_W  RAM write address.
REQ-010 SHALL have port ram_wdata  out  8  RAM write data.
REQ-011 SHALL have port cursor  out  ADDR_W  current insertion address.
REQ-012 SHALL have port busy  out  1  high in CLEAR or EXEC state.
REQ-013 SHALL have port key_drop  out  1  one-cycle pulse when a key event is discarded.

Function
REQ-014 SHALL implement states CLEAR, IDLE and EXEC only.
REQ-015 CLEAR SHALL write 0x20 to addresses 0..2^ADDR_W-1 in ascending order, one per cycle (ram_we=1), then go to IDLE with cursor=0.
REQ-016 In IDLE, a key with pending empty and key_valid=1 SHALL be latched and the FSM SHALL go to EXEC the next cycle.
REQ-017 EXEC SHALL last exactly one cycle, then return to IDLE; the key is applied on the EXEC cycle.
REQ-018 Printable key (0x20..0x7E) SHALL drive ram_we=1, ram_addr=cursor, ram_wdata=key, cursor<=cursor+1 modulo 2^ADDR_W.
REQ-019 Backspace (0x08) with cursor!=0 SHALL drive ram_we=1, ram_addr=cursor-1, ram_wdata=0x20, cursor<=cursor-1.
REQ-020 Backspace with cursor==0 SHALL write nothing and leave cursor at 0 (no wrap).
REQ-021 Return (0x0D) SHALL set cursor<=((cursor>>LINE_W)+1)<<LINE_W modulo 2^ADDR_W with ram_we=0; from the last line it wraps to 0.
REQ-022 Form feed (0x0C) SHALL enter CLEAR on the cycle after EXEC, restarting at address 0.
REQ-023 All other codes SHALL be consumed in EXEC with no write and no cursor change.
REQ-024 A key_valid while busy SHALL be stored in a one-deep pending register if that register is empty.
REQ-025 Otherwise the key SHALL be discarded, with key_drop=1 for one cycle.
REQ-026 On entry to IDLE with pending full, the pending key SHALL execute first (EXEC next cycle).
REQ-027 A key_valid in that same IDLE cycle SHALL be stored into the pending register, which is freed that cycle.
REQ-028 clear_req in any state SHALL flush the pending register and restart CLEAR from address 0 on the next cycle.
REQ-029 A key_valid coincident with clear_req SHALL be stored as pending and executed after the clear completes.
REQ-030 ram_we SHALL be 0 in IDLE.
REQ-031 ram_addr/ram_wdata are don't-care when ram_we=0, but SHALL be held stable.
REQ-032 Latency SHALL be key_valid at cycle N (IDLE, pending empty) -> ram_we at cycle N+1.

Reset
REQ-033 While reset=1, the block SHALL hold state=CLEAR, clear address=0, cursor=0, pending empty, ram_we=0, ram_addr=0, ram_wdata=0x20, busy=1, key_drop=0.
REQ-034 Reset asserted mid-operation SHALL abort the operation and discard pending.
REQ-035 The first clear write SHALL occur in the first cycle after reset deasserts; IDLE is reached 64 cycles later (ADDR_W=6).

Verification
REQ-036 Reset then idle 70 cycles -> 64 writes of 0x20 to addresses 0..63 in order, then busy=0, cursor=0.
REQ-037 Keys 'H','i',0x08 -> writes 0x48@0, 0x69@1, 0x20@1; cursor=1.
REQ-038 cursor=5, key 0x0D -> no write, cursor=16; cursor=50, 0x0D -> cursor=0; cursor=0, 0x08 -> no write, cursor=0.
REQ-039 cursor=63, key 'A' -> write 0x41@63, cursor=0.
REQ-040 key_valid on 3 consecutive cycles from IDLE -> first executes, second pends and executes, third pends and executes; key_drop never asserted.
REQ-041 During CLEAR, 2 keys sent -> first pends, second gives key_drop=1 once; clear_req mid-CLEAR -> restart at address 0, pending flushed.
